// File: rtl/sevenseg_pkg.sv
// Shared constants for the 7-segment scan controller: active-low segment codes,
// scan FSM state encoding and the BCD to segment decode function.
package sevenseg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  // Every segment and the dp lit: visible error indication for non-BCD values
  localparam logic [7:0] SEG_ERR   = 8'h00;

  typedef enum logic [0:0] {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } scan_state_e;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
    logic [7:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_ERR;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational BCD to active-low 7-segment decoder (dp off, 10..15 -> error code).
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  // Pure table lookup shared with the package decode function
  always_comb begin
    seg = bcd_to_seg(bcd);
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scan controller with blanking gap.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zeros.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int SCAN_DIV   = 1000,
  parameter  int BLANK_CYC  = 16,
  localparam int IW         = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [IW-1:0]         wr_idx,
  input  logic [3:0]            Din,
  output logic [7:0]            out,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_tick
);

  localparam int CMAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_e           state_r;
  scan_state_e           state_nxt_s;
  logic [CW-1:0]         presc_r;
  logic [CW-1:0]         presc_nxt_s;
  logic [IW-1:0]         idx_r;
  logic [IW-1:0]         idx_nxt_s;
  logic                  wrap_s;
  logic [3:0]            digit_r [NUM_DIGITS];
  logic [3:0]            cur_digit_s;
  logic [7:0]            dec_seg_s;
  logic                  lz_blank_s;
  logic [7:0]            out_nxt_s;
  logic [NUM_DIGITS-1:0] an_nxt_s;
  logic [7:0]            out_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic                  tick_r;

  // Scan state, dwell prescaler and position index
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_SHOW;
      presc_r <= '0;
      idx_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      presc_r <= presc_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Next-state: dwell SCAN_DIV cycles lit, BLANK_CYC cycles dark, then advance
  always_comb begin
    state_nxt_s = state_r;
    presc_nxt_s = presc_r + CW'(1);
    idx_nxt_s   = idx_r;
    wrap_s      = 1'b0;
    case (state_r)
      ST_SHOW: begin
        if (presc_r == SHOW_LAST) begin
          state_nxt_s = ST_BLANK;
          presc_nxt_s = '0;
        end else begin
          state_nxt_s = ST_SHOW;
        end
      end
      ST_BLANK: begin
        if (presc_r == BLANK_LAST) begin
          state_nxt_s = ST_SHOW;
          presc_nxt_s = '0;
          if (idx_r == IDX_LAST) begin
            idx_nxt_s = '0;
            wrap_s    = 1'b1;
          end else begin
            idx_nxt_s = idx_r + IW'(1);
          end
        end else begin
          state_nxt_s = ST_BLANK;
        end
      end
      default: begin
        state_nxt_s = ST_SHOW;
        presc_nxt_s = '0;
        idx_nxt_s   = '0;
      end
    endcase
  end

  // Digit registers; indices beyond NUM_DIGITS-1 match no register
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (rst) begin
        digit_r[i] <= 4'd0;
      end else if (load && (wr_idx == IW'(i))) begin
        digit_r[i] <= Din;
      end
    end
  end

  // Select the digit at the current scan position
  always_comb begin
    cur_digit_s = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cur_digit_s = (idx_r == IW'(i)) ? digit_r[i] : cur_digit_s;
    end
  end

  sevenseg_decode u_decode (
    .bcd (cur_digit_s),
    .seg (dec_seg_s)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_run_s;

  // Position i>0 is blanked when it and every higher position hold exactly 0
  always_comb begin
    zero_run_s = 1'b1;
    lz_blank_s = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run_s = zero_run_s & (digit_r[i] == 4'd0);
      lz_blank_s = (idx_r == IW'(i)) ? zero_run_s : lz_blank_s;
    end
  end
`else
  assign lz_blank_s = 1'b0;
`endif

  // Output decode: one-hot active-low enable while lit, everything dark while blanking
  always_comb begin
    out_nxt_s = SEG_BLANK;
    an_nxt_s  = '1;
    case (state_r)
      ST_SHOW: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          an_nxt_s[i] = (idx_r != IW'(i));
        end
        out_nxt_s = lz_blank_s ? SEG_BLANK : dec_seg_s;
      end
      ST_BLANK: begin
        out_nxt_s = SEG_BLANK;
        an_nxt_s  = '1;
      end
      default: begin
        out_nxt_s = SEG_BLANK;
        an_nxt_s  = '1;
      end
    endcase
  end

  // Registered pin drivers, all dark in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r  <= SEG_BLANK;
      an_r   <= '1;
      tick_r <= 1'b0;
    end else begin
      out_r  <= out_nxt_s;
      an_r   <= an_nxt_s;
      tick_r <= wrap_s;
    end
  end

  assign out        = out_r;
  assign an         = an_r;
  assign frame_tick = tick_r;

endmodule
